// File: rtl/jump_redirect_stage.sv
// jump_redirect_stage: single-entry register stage behind the jump datapath.
// Holds one jump/auipc uop and drives its valid/ready writeback.
// Issues a one-shot redirect when the computed target differs from the
// predicted target, and drops any entry that a ROB flush kills.
// Optional macro JUMP_REDIRECT_PERF_EN builds the jump and mispredict counters.
// Without it, io_perf_* are tied to zero.
module jump_redirect_stage #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned VADDR_W   = 39,
  parameter int unsigned ROB_PTR_W = 9,
  parameter int unsigned PDEST_W   = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [XLEN-1:0]      io_in_result,
  input  logic [XLEN-1:0]      io_in_target,
  input  logic                 io_in_isAuipc,
  input  logic [VADDR_W-1:0]   io_in_predTarget,
  input  logic [ROB_PTR_W-1:0] io_in_robIdx,
  input  logic [PDEST_W-1:0]   io_in_pdest,
  input  logic                 io_in_rfWen,
  input  logic                 io_flush_valid,
  input  logic [ROB_PTR_W-1:0] io_flush_robIdx,
  input  logic                 io_flush_self,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [XLEN-1:0]      io_out_data,
  output logic [ROB_PTR_W-1:0] io_out_robIdx,
  output logic [PDEST_W-1:0]   io_out_pdest,
  output logic                 io_out_rfWen,
  output logic                 io_redirect_valid,
  output logic [ROB_PTR_W-1:0] io_redirect_robIdx,
  output logic [VADDR_W-1:0]   io_redirect_target,
  output logic [63:0]          io_perf_jumpCnt,
  output logic [63:0]          io_perf_mispredCnt
);

  localparam int unsigned IDX_W = ROB_PTR_W - 1;

  // a is older than b in ROB order (wrap flag flips the index comparison)
  function automatic logic is_older(input logic [ROB_PTR_W-1:0] a,
                                    input logic [ROB_PTR_W-1:0] b);
    if (a[ROB_PTR_W-1] == b[ROB_PTR_W-1]) return a[IDX_W-1:0] < b[IDX_W-1:0];
    else                                  return a[IDX_W-1:0] > b[IDX_W-1:0];
  endfunction

  // x is squashed by the flush presented this cycle
  function automatic logic is_killed(input logic                 fv,
                                     input logic [ROB_PTR_W-1:0] fidx,
                                     input logic                 fself,
                                     input logic [ROB_PTR_W-1:0] x);
    return fv & (is_older(fidx, x) | (fself & (x == fidx)));
  endfunction

  logic                 valid_q,   valid_d;
  logic                 new_q,     new_d;
  logic [XLEN-1:0]      data_q,    data_d;
  logic [VADDR_W-1:0]   target_q,  target_d;
  logic                 auipc_q,   auipc_d;
  logic [VADDR_W-1:0]   pred_q,    pred_d;
  logic [ROB_PTR_W-1:0] rob_q,     rob_d;
  logic [PDEST_W-1:0]   pdest_q,   pdest_d;
  logic                 rfwen_q,   rfwen_d;

  logic s1_kill, in_kill, in_ready, in_fire, load;
  logic out_valid, out_fire, mis, redirect;

  // only the low VADDR_W target bits take part in the redirect
  logic unused_target_hi;
  assign unused_target_hi = ^io_in_target[XLEN-1:VADDR_W];

  // kill, handshake and next-state for the S1 entry
  always_comb begin
    valid_d  = valid_q;
    new_d    = 1'b0;
    data_d   = data_q;
    target_d = target_q;
    auipc_d  = auipc_q;
    pred_d   = pred_q;
    rob_d    = rob_q;
    pdest_d  = pdest_q;
    rfwen_d  = rfwen_q;

    s1_kill   = valid_q & is_killed(io_flush_valid, io_flush_robIdx, io_flush_self, rob_q);
    in_kill   = is_killed(io_flush_valid, io_flush_robIdx, io_flush_self, io_in_robIdx);
    in_ready  = ~valid_q | io_out_ready | s1_kill;
    in_fire   = io_in_valid & in_ready;
    load      = in_fire & ~in_kill;
    out_valid = valid_q & ~s1_kill;
    out_fire  = out_valid & io_out_ready;
    mis       = ~auipc_q & (target_q != pred_q);
    redirect  = valid_q & new_q & mis & ~s1_kill;

    if (load) begin
      valid_d  = 1'b1;
      new_d    = 1'b1;
      data_d   = io_in_result;
      target_d = io_in_target[VADDR_W-1:0];
      auipc_d  = io_in_isAuipc;
      pred_d   = io_in_predTarget;
      rob_d    = io_in_robIdx;
      pdest_d  = io_in_pdest;
      rfwen_d  = io_in_rfWen;
    end else if (out_fire || s1_kill) begin
      valid_d  = 1'b0;
    end
  end

  // S1 entry register
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      new_q    <= 1'b0;
      data_q   <= '0;
      target_q <= '0;
      auipc_q  <= 1'b0;
      pred_q   <= '0;
      rob_q    <= '0;
      pdest_q  <= '0;
      rfwen_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      new_q    <= new_d;
      data_q   <= data_d;
      target_q <= target_d;
      auipc_q  <= auipc_d;
      pred_q   <= pred_d;
      rob_q    <= rob_d;
      pdest_q  <= pdest_d;
      rfwen_q  <= rfwen_d;
    end
  end

  assign io_in_ready        = in_ready;
  assign io_out_valid       = out_valid;
  assign io_out_data        = data_q;
  assign io_out_robIdx      = rob_q;
  assign io_out_pdest       = pdest_q;
  assign io_out_rfWen       = rfwen_q;
  assign io_redirect_valid  = redirect;
  assign io_redirect_robIdx = rob_q;
  assign io_redirect_target = target_q;

`ifdef JUMP_REDIRECT_PERF_EN
  logic [63:0] jump_cnt_q, mispred_cnt_q;

  // wrapping event counters for written-back jumps and issued redirects
  always_ff @(posedge clock) begin
    if (reset) begin
      jump_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (out_fire && !auipc_q) jump_cnt_q    <= 64'(jump_cnt_q + 64'd1);
      if (redirect)             mispred_cnt_q <= 64'(mispred_cnt_q + 64'd1);
    end
  end

  assign io_perf_jumpCnt    = jump_cnt_q;
  assign io_perf_mispredCnt = mispred_cnt_q;
`else
  assign io_perf_jumpCnt    = 64'd0;
  assign io_perf_mispredCnt = 64'd0;
`endif

endmodule

// File: tb/tb_jump_redirect_stage.sv
// Directed self-checking bench for jump_redirect_stage.
module tb_jump_redirect_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [63:0] io_in_result;
  logic [63:0] io_in_target;
  logic        io_in_isAuipc;
  logic [38:0] io_in_predTarget;
  logic [8:0]  io_in_robIdx;
  logic [6:0]  io_in_pdest;
  logic        io_in_rfWen;
  logic        io_flush_valid;
  logic [8:0]  io_flush_robIdx;
  logic        io_flush_self;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_out_data;
  logic [8:0]  io_out_robIdx;
  logic [6:0]  io_out_pdest;
  logic        io_out_rfWen;
  logic        io_redirect_valid;
  logic [8:0]  io_redirect_robIdx;
  logic [38:0] io_redirect_target;
  logic [63:0] io_perf_jumpCnt;
  logic [63:0] io_perf_mispredCnt;

  int total = 0;
  int bad   = 0;

  jump_redirect_stage dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_result       (io_in_result),
    .io_in_target       (io_in_target),
    .io_in_isAuipc      (io_in_isAuipc),
    .io_in_predTarget   (io_in_predTarget),
    .io_in_robIdx       (io_in_robIdx),
    .io_in_pdest        (io_in_pdest),
    .io_in_rfWen        (io_in_rfWen),
    .io_flush_valid     (io_flush_valid),
    .io_flush_robIdx    (io_flush_robIdx),
    .io_flush_self      (io_flush_self),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_data        (io_out_data),
    .io_out_robIdx      (io_out_robIdx),
    .io_out_pdest       (io_out_pdest),
    .io_out_rfWen       (io_out_rfWen),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_robIdx (io_redirect_robIdx),
    .io_redirect_target (io_redirect_target),
    .io_perf_jumpCnt    (io_perf_jumpCnt),
    .io_perf_mispredCnt (io_perf_mispredCnt)
  );

  always #5 clock = ~clock;

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [63:0] res, input logic [63:0] tgt, input logic auipc,
                       input logic [38:0] pred, input logic [8:0] rob, input logic [6:0] pd,
                       input logic wen);
    io_in_valid      = 1'b1;
    io_in_result     = res;
    io_in_target     = tgt;
    io_in_isAuipc    = auipc;
    io_in_predTarget = pred;
    io_in_robIdx     = rob;
    io_in_pdest      = pd;
    io_in_rfWen      = wen;
  endtask

  task automatic idle();
    io_in_valid = 1'b0;
  endtask

  task automatic flush(input logic v, input logic [8:0] idx, input logic slf);
    io_flush_valid  = v;
    io_flush_robIdx = idx;
    io_flush_self   = slf;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    io_in_result = '0; io_in_target = '0; io_in_isAuipc = 1'b0; io_in_predTarget = '0;
    io_in_robIdx = '0; io_in_pdest = '0; io_in_rfWen = 1'b0;
    flush(1'b0, 9'h0, 1'b0);
    io_out_ready = 1'b0;
    tick(); tick();
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", io_out_valid); end
    total++; if (io_redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", io_redirect_valid); end
    total++; if (io_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", io_in_ready); end
    total++; if (io_out_data !== 64'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", io_out_data); end
    total++; if (io_perf_jumpCnt !== 64'd0 || io_perf_mispredCnt !== 64'd0) begin
      bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", io_perf_jumpCnt, io_perf_mispredCnt); end
    reset = 1'b0;
  endtask

  task automatic test_jal();
    io_out_ready = 1'b1;
    drive(64'h1004, 64'h1040, 1'b0, 39'h1040, 9'h005, 7'd12, 1'b1);
    #1;
    total++; if (io_in_ready !== 1'b1) begin bad++; $display("FAIL jal_in_ready got=%b exp=1", io_in_ready); end
    tick();
    drive(64'h2008, 64'hABCD_0000_0000_3000, 1'b0, 39'h3000, 9'h006, 7'd13, 1'b0);
    #1;
    total++; if (io_out_valid !== 1'b1) begin bad++; $display("FAIL jal_out_valid got=%b exp=1", io_out_valid); end
    total++; if (io_out_data !== 64'h1004) begin bad++; $display("FAIL jal_data got=%h exp=1004", io_out_data); end
    total++; if (io_out_robIdx !== 9'h005 || io_out_pdest !== 7'd12 || io_out_rfWen !== 1'b1) begin
      bad++; $display("FAIL jal_tags got=%h/%0d/%b exp=005/12/1", io_out_robIdx, io_out_pdest, io_out_rfWen); end
    total++; if (io_redirect_valid !== 1'b0) begin bad++; $display("FAIL jal_redirect got=%b exp=0", io_redirect_valid); end
    tick();
    idle();
    #1;
    total++; if (io_out_valid !== 1'b1 || io_out_data !== 64'h2008 || io_out_rfWen !== 1'b0) begin
      bad++; $display("FAIL hibits_out got=%b/%h/%b exp=1/2008/0", io_out_valid, io_out_data, io_out_rfWen); end
    total++; if (io_redirect_valid !== 1'b0) begin bad++; $display("FAIL hibits_redirect got=%b exp=0", io_redirect_valid); end
    tick();
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL jal_drain got=%b exp=0", io_out_valid); end
  endtask

  task automatic test_jalr_mispredict();
    io_out_ready = 1'b0;
    drive(64'h1008, 64'h2000, 1'b0, 39'h2004, 9'h007, 7'd20, 1'b1);
    tick();
    idle();
    #1;
    total++; if (io_redirect_valid !== 1'b1) begin bad++; $display("FAIL jalr_redirect got=%b exp=1", io_redirect_valid); end
    total++; if (io_redirect_target !== 39'h2000) begin bad++; $display("FAIL jalr_rtarget got=%h exp=2000", io_redirect_target); end
    total++; if (io_redirect_robIdx !== 9'h007) begin bad++; $display("FAIL jalr_rrob got=%h exp=007", io_redirect_robIdx); end
    total++; if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0) begin
      bad++; $display("FAIL jalr_stall got=%b/%b exp=1/0", io_out_valid, io_in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (io_redirect_valid !== 1'b0) begin bad++; $display("FAIL jalr_second_redirect cyc=%0d got=%b exp=0", i, io_redirect_valid); end
      total++; if (io_out_valid !== 1'b1 || io_out_data !== 64'h1008 || io_out_robIdx !== 9'h007) begin
        bad++; $display("FAIL jalr_hold cyc=%0d got=%b/%h/%h exp=1/1008/007", i, io_out_valid, io_out_data, io_out_robIdx); end
    end
    io_out_ready = 1'b1;
    #1;
    total++; if (io_in_ready !== 1'b1) begin bad++; $display("FAIL jalr_release_ready got=%b exp=1", io_in_ready); end
    tick();
    total++; if (io_out_valid !== 1'b0 || io_redirect_valid !== 1'b0) begin
      bad++; $display("FAIL jalr_drain got=%b/%b exp=0/0", io_out_valid, io_redirect_valid); end
  endtask

  task automatic test_auipc();
    io_out_ready = 1'b1;
    drive(64'h8000_1000, 64'h5000, 1'b1, 39'h1234, 9'h008, 7'd3, 1'b1);
    tick();
    idle();
    #1;
    total++; if (io_out_valid !== 1'b1 || io_out_data !== 64'h8000_1000) begin
      bad++; $display("FAIL auipc_out got=%b/%h exp=1/80001000", io_out_valid, io_out_data); end
    total++; if (io_redirect_valid !== 1'b0) begin bad++; $display("FAIL auipc_redirect got=%b exp=0", io_redirect_valid); end
    tick();
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL auipc_drain got=%b exp=0", io_out_valid); end
  endtask

  task automatic test_flush();
    io_out_ready = 1'b0;
    // younger mispredicting entry killed on its first cycle
    drive(64'h10, 64'h6000, 1'b0, 39'h6008, 9'h005, 7'd1, 1'b1);
    tick();
    idle();
    flush(1'b1, 9'h003, 1'b0);
    #1;
    total++; if (io_out_valid !== 1'b0 || io_redirect_valid !== 1'b0) begin
      bad++; $display("FAIL flush_kill got=%b/%b exp=0/0", io_out_valid, io_redirect_valid); end
    total++; if (io_in_ready !== 1'b1) begin bad++; $display("FAIL flush_kill_ready got=%b exp=1", io_in_ready); end
    tick();
    flush(1'b0, 9'h0, 1'b0);
    #1;
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", io_out_valid); end
    // entry older than the flush survives
    drive(64'h20, 64'h6000, 1'b0, 39'h6000, 9'h005, 7'd2, 1'b1);
    tick();
    idle();
    flush(1'b1, 9'h102, 1'b0);
    #1;
    total++; if (io_out_valid !== 1'b1) begin bad++; $display("FAIL flush_older_survive got=%b exp=1", io_out_valid); end
    tick();
    flush(1'b0, 9'h0, 1'b0);
    #1;
    total++; if (io_out_valid !== 1'b1 || io_out_data !== 64'h20) begin
      bad++; $display("FAIL flush_survive_hold got=%b/%h exp=1/20", io_out_valid, io_out_data); end
    // self flush kills the matching entry
    flush(1'b1, 9'h005, 1'b1);
    #1;
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL flush_self got=%b exp=0", io_out_valid); end
    tick();
    // incoming uop younger than the flush is discarded
    flush(1'b1, 9'h003, 1'b0);
    drive(64'h30, 64'h6000, 1'b0, 39'h6000, 9'h006, 7'd3, 1'b1);
    tick();
    idle();
    flush(1'b0, 9'h0, 1'b0);
    #1;
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL flush_in_kill got=%b exp=0", io_out_valid); end
  endtask

  task automatic test_back_to_back();
    io_out_ready = 1'b1;
    drive(64'h100, 64'h7000, 1'b0, 39'h7000, 9'h010, 7'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) drive(64'(64'h101 + i), 64'h7000, 1'b0, 39'h7000, 9'(9'h011 + i), 7'(i + 1), 1'b1);
      else idle();
      #1;
      total++; if (io_out_valid !== 1'b1 || io_out_data !== 64'(64'h100 + i) || io_out_robIdx !== 9'(9'h010 + i)) begin
        bad++; $display("FAIL b2b_wb%0d got=%b/%h/%h exp=1/%h/%h", i, io_out_valid, io_out_data, io_out_robIdx,
                        64'(64'h100 + i), 9'(9'h010 + i)); end
    end
    tick();
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", io_out_valid); end
    // stalled writeback blocks intake until the next out fire
    io_out_ready = 1'b0;
    drive(64'h200, 64'h7000, 1'b0, 39'h7000, 9'h020, 7'd5, 1'b1);
    tick();
    drive(64'h201, 64'h7000, 1'b0, 39'h7000, 9'h021, 7'd6, 1'b1);
    #1;
    total++; if (io_in_ready !== 1'b0 || io_out_data !== 64'h200) begin
      bad++; $display("FAIL stall_ready got=%b/%h exp=0/200", io_in_ready, io_out_data); end
    tick();
    total++; if (io_in_ready !== 1'b0 || io_out_data !== 64'h200) begin
      bad++; $display("FAIL stall_hold got=%b/%h exp=0/200", io_in_ready, io_out_data); end
    io_out_ready = 1'b1;
    #1;
    total++; if (io_in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", io_in_ready); end
    tick();
    idle();
    #1;
    total++; if (io_out_valid !== 1'b1 || io_out_data !== 64'h201) begin
      bad++; $display("FAIL stall_next got=%b/%h exp=1/201", io_out_valid, io_out_data); end
    tick();
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", io_out_valid); end
  endtask

  task automatic test_reset_mid();
    io_out_ready = 1'b0;
    drive(64'h40, 64'h8000, 1'b0, 39'h8004, 9'h030, 7'd7, 1'b1);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (io_out_valid !== 1'b0 || io_redirect_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_drop got=%b/%b exp=0/0", io_out_valid, io_redirect_valid); end
    reset = 1'b1;
    drive(64'h41, 64'h8000, 1'b0, 39'h8004, 9'h031, 7'd8, 1'b1);
    tick();
    reset = 1'b0;
    idle();
    #1;
    total++; if (io_out_valid !== 1'b0 || io_redirect_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_capture got=%b/%b exp=0/0", io_out_valid, io_redirect_valid); end
  endtask

  task automatic test_perf();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    io_out_ready = 1'b1;
    drive(64'h50, 64'h9000, 1'b0, 39'h9000, 9'h040, 7'd1, 1'b1);
    tick();
    drive(64'h51, 64'h9100, 1'b0, 39'h9104, 9'h041, 7'd2, 1'b1);
    tick();
    drive(64'h52, 64'h9200, 1'b1, 39'h1111, 9'h042, 7'd3, 1'b1);
    tick();
    drive(64'h53, 64'h9300, 1'b0, 39'h9300, 9'h043, 7'd4, 1'b1);
    tick();
    idle();
    tick();
`ifdef JUMP_REDIRECT_PERF_EN
    total++; if (io_perf_jumpCnt !== 64'd3) begin bad++; $display("FAIL perf_jump got=%0d exp=3", io_perf_jumpCnt); end
    total++; if (io_perf_mispredCnt !== 64'd1) begin bad++; $display("FAIL perf_mispred got=%0d exp=1", io_perf_mispredCnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
`endif
    total++; if (io_perf_jumpCnt !== 64'd0 || io_perf_mispredCnt !== 64'd0) begin
      bad++; $display("FAIL perf_zero got=%0d/%0d exp=0/0", io_perf_jumpCnt, io_perf_mispredCnt); end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_jalr_mispredict();
    test_auipc();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
